day2_demux: RTL and testbench

//   1:2 streaming demultiplexer; the inverse of the team's 8-bit 2:1 mux.

---
 rtl/day2_demux.sv | 153 +++++++++++++++
 tb/tb_day2_demux.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/day2_demux.sv
// day2_demux: 1:2 valid/ready byte-stream demultiplexer. Each output owns a
// DEPTH-entry FIFO and a wrapping count of completed output handshakes.

module day2_demux_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } status_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    status_t          status;
    logic             pop;
    logic             do_push;

    always_comb begin
        if (occ == '0) begin
            status = ST_EMPTY;
        end else if (occ == OCC_FULL) begin
            status = ST_FULL;
        end else begin
            status = ST_PARTIAL;
        end
    end

    assign full  = (status == ST_FULL);
    assign valid = (status != ST_EMPTY);
    // Head is gated so an empty FIFO never exposes a stale byte.
    assign data    = valid ? mem[rd_ptr] : '0;
    assign pop     = valid && ready;
    assign do_push = push && !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                count  <= count + CNT_ONE;
            end
            case ({do_push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end
endmodule

module day2_demux #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);
    logic a_full;
    logic b_full;
    logic accept;
    logic a_push;
    logic b_push;

    // Ready looks only at fullness, never at the consumers' ready inputs.
    assign in_ready = rst_n && (in_sel ? !a_full : !b_full);
    assign accept   = in_valid && in_ready;
    assign a_push   = accept && in_sel;
    assign b_push   = accept && !in_sel;

    day2_demux_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_fifo_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (a_push),
        .push_data(in_data),
        .full     (a_full),
        .valid    (a_valid),
        .data     (a_data),
        .ready    (a_ready),
        .count    (a_count)
    );

    day2_demux_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_fifo_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (b_push),
        .push_data(in_data),
        .full     (b_full),
        .valid    (b_valid),
        .data     (b_data),
        .ready    (b_ready),
        .count    (b_count)
    );
endmodule

// File: tb/tb_day2_demux.sv
// Bench for day2_demux: directed scenarios plus a randomized run, all checked
// against a queue-based model of the two output streams.

module tb_day2_demux;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [CNT_W-1:0] a_count;
    logic [CNT_W-1:0] b_count;

    always #5 clk = ~clk;

    day2_demux #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_sel  (in_sel),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .a_count (a_count),
        .b_count (b_count)
    );

    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    int ca;
    int cb;
    int nvec = 0;
    int nmis = 0;

    function automatic bit exp_ready();
        if (!rst_n) return 1'b0;
        return in_sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH);
    endfunction

    function automatic logic [WIDTH-1:0] exp_head(input bit sel);
        if (sel) return (qa.size() > 0) ? qa[0] : '0;
        return (qb.size() > 0) ? qb[0] : '0;
    endfunction

    // Advance the model across one rising edge using the inputs seen just before it.
    task automatic tick();
        bit               pa;
        bit               pb;
        bit               acc;
        bit               sel;
        logic [WIDTH-1:0] d;
        pa  = a_ready && (qa.size() > 0);
        pb  = b_ready && (qb.size() > 0);
        acc = in_valid && exp_ready();
        sel = in_sel;
        d   = in_data;
        @(posedge clk);
        #1;
        if (pa) begin
            void'(qa.pop_front());
            ca = (ca + 1) % CNT_MOD;
        end
        if (pb) begin
            void'(qb.pop_front());
            cb = (cb + 1) % CNT_MOD;
        end
        if (acc) begin
            if (sel) qa.push_back(d);
            else qb.push_back(d);
        end
    endtask

    task automatic model_clear();
        qa.delete();
        qb.delete();
        ca = 0;
        cb = 0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        #2;
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 1'b1;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        model_clear();
        #12;
        nvec++; if (a_valid !== 1'b0) begin nmis++; $display("FAIL rst_a_valid got=%b want=0", a_valid); end
        nvec++; if (b_valid !== 1'b0) begin nmis++; $display("FAIL rst_b_valid got=%b want=0", b_valid); end
        nvec++; if (a_count !== 4'd0) begin nmis++; $display("FAIL rst_a_count got=%0d want=0", a_count); end
        nvec++; if (b_count !== 4'd0) begin nmis++; $display("FAIL rst_b_count got=%0d want=0", b_count); end
        nvec++; if (in_ready !== 1'b0) begin nmis++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        nvec++; if (a_data !== 8'h00) begin nmis++; $display("FAIL rst_a_data got=%h want=00", a_data); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nmis++; $display("FAIL rel_in_ready_a got=%b want=1", in_ready); end
        in_sel = 1'b0;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nmis++; $display("FAIL rel_in_ready_b got=%b want=1", in_ready); end
    endtask

    task automatic test_route();
        do_reset();
        a_ready = 1'b1; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h11;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nmis++; $display("FAIL route_ready got=%b want=1", in_ready); end
        tick();
        in_sel = 1'b0; in_data = 8'h22;
        #1;
        nvec++; if ({a_valid, a_data} !== {1'b1, 8'h11}) begin nmis++; $display("FAIL route_a got=%b/%h want=1/11", a_valid, a_data); end
        nvec++; if (b_valid !== 1'b0) begin nmis++; $display("FAIL route_b_early got=%b want=0", b_valid); end
        tick();
        in_valid = 1'b0;
        #1;
        nvec++; if ({b_valid, b_data} !== {1'b1, 8'h22}) begin nmis++; $display("FAIL route_b got=%b/%h want=1/22", b_valid, b_data); end
        nvec++; if (a_count !== 4'd1) begin nmis++; $display("FAIL route_a_count got=%0d want=1", a_count); end
        tick();
        nvec++; if (b_count !== 4'd1) begin nmis++; $display("FAIL route_b_count got=%0d want=1", b_count); end
        nvec++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin nmis++; $display("FAIL route_drain got=%b%b want=00", a_valid, b_valid); end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] got[$];
        bit acc_now;
        do_reset();
        in_valid = 1'b1; in_sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hA0 + 8'(i);
            #1;
            nvec++; if (in_ready !== (i < 2)) begin nmis++; $display("FAIL bp_ready beat=%0d got=%b want=%b", i, in_ready, (i < 2)); end
            if (i < 2) tick();
        end
        tick();
        nvec++; if (in_ready !== 1'b0 || a_data !== 8'hA0) begin nmis++; $display("FAIL bp_hold got=%b/%h want=0/a0", in_ready, a_data); end
        a_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (a_valid) got.push_back(a_data);
            acc_now = in_valid && in_ready;
            tick();
            if (acc_now) in_valid = 1'b0;
        end
        nvec++; if (got.size() !== 3) begin nmis++; $display("FAIL bp_n_out got=%0d want=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            nvec++; if (got[i] !== 8'hA0 + 8'(i)) begin nmis++; $display("FAIL bp_order idx=%0d got=%h want=%h", i, got[i], 8'hA0 + 8'(i)); end
        end
        nvec++; if (a_count !== 4'd3) begin nmis++; $display("FAIL bp_count got=%0d want=3", a_count); end
    endtask

    task automatic test_push_pop_same();
        do_reset();
        in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h33;
        tick();
        in_data = 8'h5C; a_ready = 1'b1;
        #1;
        nvec++; if (in_ready !== 1'b1 || a_data !== 8'h33) begin nmis++; $display("FAIL pp_pre got=%b/%h want=1/33", in_ready, a_data); end
        tick();
        in_valid = 1'b0; a_ready = 1'b0;
        #1;
        nvec++; if ({a_valid, a_data} !== {1'b1, 8'h5C}) begin nmis++; $display("FAIL pp_head got=%b/%h want=1/5c", a_valid, a_data); end
        nvec++; if (in_ready !== 1'b1 || a_count !== 4'd1) begin nmis++; $display("FAIL pp_occ got=%b/%0d want=1/1", in_ready, a_count); end
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h77; a_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        nvec++; if (a_valid !== 1'b0 || a_count !== 4'd2) begin nmis++; $display("FAIL pp_apop got=%b/%0d want=0/2", a_valid, a_count); end
        nvec++; if ({b_valid, b_data} !== {1'b1, 8'h77}) begin nmis++; $display("FAIL pp_bpush got=%b/%h want=1/77", b_valid, b_data); end
    endtask

    task automatic test_count_wrap();
        bit saw_max;
        bit saw_wrap;
        saw_max = 1'b0; saw_wrap = 1'b0;
        do_reset();
        a_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b1;
        for (int i = 0; i < 18; i++) begin
            in_data = 8'(i);
            if (i == 17) in_valid = 1'b0;
            #1;
            nvec++; if (a_count !== 4'(ca)) begin nmis++; $display("FAIL wrap_step i=%0d got=%0d want=%0d", i, a_count, ca); end
            if (a_count == 4'd15) saw_max = 1'b1;
            if (saw_max && a_count == 4'd0) saw_wrap = 1'b1;
            tick();
        end
        nvec++; if (a_count !== 4'd1 || b_count !== 4'd0) begin nmis++; $display("FAIL wrap_end got=%0d/%0d want=1/0", a_count, b_count); end
        nvec++; if (!(saw_max && saw_wrap)) begin nmis++; $display("FAIL wrap_seq got=%b%b want=11", saw_max, saw_wrap); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h90; a_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        a_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_sel  = (i < 2);
            in_data = 8'hC0 + 8'(i);
            tick();
        end
        in_valid = 1'b0; in_sel = 1'b1;
        #1;
        nvec++; if ({a_valid, b_valid, in_ready} !== 3'b110) begin nmis++; $display("FAIL mid_pre got=%b want=110", {a_valid, b_valid, in_ready}); end
        nvec++; if (a_count !== 4'd1) begin nmis++; $display("FAIL mid_pre_count got=%0d want=1", a_count); end
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        nvec++; if ({a_valid, b_valid, in_ready} !== 3'b000) begin nmis++; $display("FAIL mid_async got=%b want=000", {a_valid, b_valid, in_ready}); end
        nvec++; if ({a_count, b_count} !== 8'h00 || a_data !== 8'h00) begin nmis++; $display("FAIL mid_clear got=%0d/%0d/%h want=0/0/00", a_count, b_count, a_data); end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 8'hE1;
        #1;
        nvec++; if (a_valid !== 1'b0) begin nmis++; $display("FAIL mid_stale got=%b want=0", a_valid); end
        tick();
        in_valid = 1'b0;
        #1;
        nvec++; if ({a_valid, a_data} !== {1'b1, 8'hE1}) begin nmis++; $display("FAIL mid_first got=%b/%h want=1/e1", a_valid, a_data); end
    endtask

    task automatic test_random();
        bit hold;
        hold = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
            end
            a_ready = ($urandom_range(0, 9) < 6);
            b_ready = ($urandom_range(0, 9) < 4);
            #1;
            nvec++; if (in_ready !== exp_ready()) begin nmis++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_ready()); end
            nvec++; if (a_valid !== (qa.size() > 0)) begin nmis++; $display("FAIL rnd_a_valid cyc=%0d got=%b want=%b", cyc, a_valid, qa.size() > 0); end
            nvec++; if (b_valid !== (qb.size() > 0)) begin nmis++; $display("FAIL rnd_b_valid cyc=%0d got=%b want=%b", cyc, b_valid, qb.size() > 0); end
            nvec++; if (a_data !== exp_head(1'b1)) begin nmis++; $display("FAIL rnd_a_data cyc=%0d got=%h want=%h", cyc, a_data, exp_head(1'b1)); end
            nvec++; if (b_data !== exp_head(1'b0)) begin nmis++; $display("FAIL rnd_b_data cyc=%0d got=%h want=%h", cyc, b_data, exp_head(1'b0)); end
            nvec++; if (a_count !== 4'(ca)) begin nmis++; $display("FAIL rnd_a_count cyc=%0d got=%0d want=%0d", cyc, a_count, ca); end
            nvec++; if (b_count !== 4'(cb)) begin nmis++; $display("FAIL rnd_b_count cyc=%0d got=%0d want=%0d", cyc, b_count, cb); end
            hold = in_valid && !exp_ready();
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_route();
        test_backpressure();
        test_push_pop_same();
        test_count_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
